// File: rtl/cmplx_sqrt_dispatcher_pkg.sv
// Shared types and default sizes for the complex square-root dispatcher.
// The dispatcher FSM encoding is fixed so it can be read directly from waveforms.
package cmplx_sqrt_dispatcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } disp_state_t;

    localparam int DEF_DW      = 16;
    localparam int DEF_NW      = 8;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_TW      = 8;

endpackage

// File: rtl/cmplx_sample_fifo.sv
// Small synchronous FIFO holding packed {N, x, y} samples for the dispatcher.
// The head entry is presented combinationally; the consumer registers it on pop.
module cmplx_sample_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    import cmplx_sqrt_dispatcher_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [DEPTH-1:0] entry_we;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rd_data = mem_reg[rd_ptr_reg];

    // A push while full is dropped, so the source keeps its sample.
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
        assign entry_we[gi] = do_push && (wr_ptr_reg == AW'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i]) begin
                mem_reg[i] <= wr_data;
            end
        end
    end

    // Depth is a power of two, so the pointers wrap on natural overflow.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule

// File: rtl/cmplx_sqrt_dispatcher.sv
// Feeds buffered complex samples to the square-root core one job at a time and
// returns each result (or a zeroed, timeout-flagged result) on a valid/ready stream.
module cmplx_sqrt_dispatcher
    import cmplx_sqrt_dispatcher_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int NW         = DEF_NW,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int TW         = DEF_TW
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DW-1:0]                 s_x,
    input  logic [DW-1:0]                 s_y,
    input  logic [NW-1:0]                 s_N,
    output logic                          sq_start,
    output logic [DW-1:0]                 sq_x,
    output logic [DW-1:0]                 sq_y,
    output logic [NW-1:0]                 sq_N,
    input  logic                          sq_valid,
    input  logic [DW-1:0]                 sq_real,
    input  logic [DW-1:0]                 sq_img,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DW-1:0]                 m_real,
    output logic [DW-1:0]                 m_img,
    output logic                          m_timeout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int FW = NW + 2 * DW;

    disp_state_t    state_reg, state_next;
    logic [DW-1:0]  sq_x_reg, sq_x_next;
    logic [DW-1:0]  sq_y_reg, sq_y_next;
    logic [NW-1:0]  sq_n_reg, sq_n_next;
    logic [DW-1:0]  m_real_reg, m_real_next;
    logic [DW-1:0]  m_img_reg, m_img_next;
    logic           m_timeout_reg, m_timeout_next;
    logic [TW-1:0]  tmo_cnt_reg, tmo_cnt_next;
    logic [TW-1:0]  tmo_cnt_inc;
    logic           armed_reg, armed_next;

    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FW-1:0]  fifo_rd_data;

    cmplx_sample_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s_valid),
        .wr_data ({s_N, s_x, s_y}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign s_ready     = !fifo_full;
    assign sq_start    = (state_reg == ST_ISSUE);
    assign m_valid     = (state_reg == ST_HOLD);
    assign busy        = (state_reg != ST_IDLE) || !fifo_empty;
    assign sq_x        = sq_x_reg;
    assign sq_y        = sq_y_reg;
    assign sq_N        = sq_n_reg;
    assign m_real      = m_real_reg;
    assign m_img       = m_img_reg;
    assign m_timeout   = m_timeout_reg;
    assign tmo_cnt_inc = tmo_cnt_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        sq_x_next      = sq_x_reg;
        sq_y_next      = sq_y_reg;
        sq_n_next      = sq_n_reg;
        m_real_next    = m_real_reg;
        m_img_next     = m_img_reg;
        m_timeout_next = m_timeout_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        armed_next     = armed_reg;
        fifo_pop       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    sq_n_next  = fifo_rd_data[FW-1 -: NW];
                    sq_x_next  = fifo_rd_data[2*DW-1 -: DW];
                    sq_y_next  = fifo_rd_data[DW-1:0];
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_next = '0;
                armed_next   = 1'b0;
                state_next   = ST_WAIT;
            end
            ST_WAIT: begin
                // A valid still high from the previous job is ignored until
                // the core has been seen to drop it at least once.
                if (!sq_valid) begin
                    armed_next = 1'b1;
                end
                if (armed_reg && sq_valid) begin
                    m_real_next    = sq_real;
                    m_img_next     = sq_img;
                    m_timeout_next = 1'b0;
                    state_next     = ST_HOLD;
                end else begin
                    tmo_cnt_next = tmo_cnt_inc;
                    if (tmo_cnt_inc == TW'(TIMEOUT)) begin
                        m_real_next    = '0;
                        m_img_next     = '0;
                        m_timeout_next = 1'b1;
                        state_next     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            sq_x_reg      <= '0;
            sq_y_reg      <= '0;
            sq_n_reg      <= '0;
            m_real_reg    <= '0;
            m_img_reg     <= '0;
            m_timeout_reg <= 1'b0;
            tmo_cnt_reg   <= '0;
            armed_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sq_x_reg      <= sq_x_next;
            sq_y_reg      <= sq_y_next;
            sq_n_reg      <= sq_n_next;
            m_real_reg    <= m_real_next;
            m_img_reg     <= m_img_next;
            m_timeout_reg <= m_timeout_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            armed_reg     <= armed_next;
        end
    end

endmodule

// File: tb/tb_cmplx_sqrt_dispatcher.sv
// Directed bench for cmplx_sqrt_dispatcher with a behavioural core returning
// (x+1, y+1) twenty cycles after each start.
module tb_cmplx_sqrt_dispatcher;

    localparam int DW = 16;
    localparam int NW = 8;
    localparam int FD = 4;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  n;
        logic [15:0] er;
        logic [15:0] ei;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  n;
    } start_t;

    typedef struct {
        int          cyc;
        logic [15:0] r;
        logic [15:0] i;
        logic        t;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_x = '0;
    logic [DW-1:0] s_y = '0;
    logic [NW-1:0] s_N = '0;
    logic          sq_start;
    logic [DW-1:0] sq_x, sq_y;
    logic [NW-1:0] sq_N;
    logic          sq_valid;
    logic [DW-1:0] sq_real, sq_img;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_real, m_img;
    logic          m_timeout;
    logic          busy;
    logic [2:0]    fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int max_cnt  = 0;
    logic mv_prev = 1'b0;

    vec_t   tbl [10];
    start_t start_q [$];
    res_t   res_q [$];

    cmplx_sqrt_dispatcher #(
        .DW (DW), .NW (NW), .FIFO_DEPTH (FD), .TIMEOUT (255), .TW (8)
    ) dut (
        .clk (clk), .rst (rst),
        .s_valid (s_valid), .s_ready (s_ready), .s_x (s_x), .s_y (s_y), .s_N (s_N),
        .sq_start (sq_start), .sq_x (sq_x), .sq_y (sq_y), .sq_N (sq_N),
        .sq_valid (sq_valid), .sq_real (sq_real), .sq_img (sq_img),
        .m_valid (m_valid), .m_ready (m_ready), .m_real (m_real), .m_img (m_img),
        .m_timeout (m_timeout), .busy (busy), .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: current job plus the tail of the previous job's valid window,
    // so a long valid can overlap the start of the next job.
    logic        resp_en  = 1'b1;
    int          hold_len = 1;
    logic [15:0] cur_r = '0, cur_i = '0, prv_r = '0, prv_i = '0;
    int          cur_done = 0, prv_end = 0;
    logic        cur_have = 1'b0, cur_resp = 1'b0;
    logic        cur_on, prv_on;

    always @(posedge clk) begin
        if (sq_start) begin
            prv_r    <= cur_r;
            prv_i    <= cur_i;
            prv_end  <= (cur_have && cur_resp && cyc >= cur_done) ? cur_done + hold_len : 0;
            cur_r    <= sq_x + 16'd1;
            cur_i    <= sq_y + 16'd1;
            cur_done <= cyc + 20;
            cur_have <= 1'b1;
            cur_resp <= resp_en;
        end
    end

    assign cur_on   = cur_have && cur_resp && (cyc >= cur_done) && (cyc < cur_done + hold_len);
    assign prv_on   = (cyc < prv_end);
    assign sq_valid = cur_on || prv_on;
    assign sq_real  = cur_on ? cur_r : prv_r;
    assign sq_img   = cur_on ? cur_i : prv_i;

    always @(negedge clk) begin
        start_t st;
        res_t   rs;
        if (rst) begin
            if (sq_start) begin
                st.cyc = cyc; st.x = sq_x; st.y = sq_y; st.n = sq_N;
                start_q.push_back(st);
            end
            if (m_valid && !mv_prev) begin
                rs.cyc = cyc; rs.r = m_real; rs.i = m_img; rs.t = m_timeout;
                res_q.push_back(rs);
            end
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
        mv_prev = m_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input vec_t v, output int acc);
        int guard = 0;
        s_valid = 1'b1; s_x = v.x; s_y = v.y; s_N = v.n;
        while (!s_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("push_accept", {31'd0, s_ready}, 32'd1);
        acc = cyc;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_res(input int n, input int budget, input string tag);
        int k = 0;
        while (res_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_result_count"}, res_q.size(), n);
    endtask

    task automatic chk_job(input string tag, input int i, input vec_t v);
        if (i >= res_q.size() || i >= start_q.size()) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_missing: got %0d results, required index %0d", tag, res_q.size(), i);
            return;
        end
        chk({tag, "_sq_x"}, start_q[i].x, v.x);
        chk({tag, "_sq_y"}, start_q[i].y, v.y);
        chk({tag, "_sq_N"}, start_q[i].n, v.n);
        chk({tag, "_real"}, res_q[i].r, v.er);
        chk({tag, "_img"}, res_q[i].i, v.ei);
        chk({tag, "_timeout"}, res_q[i].t, 0);
        chk({tag, "_latency"}, res_q[i].cyc - start_q[i].cyc, 21);
    endtask

    task automatic clear_q();
        start_q.delete();
        res_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc [6];
        int p;
        int guard;
        vec_t to_v;

        tbl[0] = '{16'h4000, 16'h0000, 8'd16,  16'h4001, 16'h0001};
        tbl[1] = '{16'hFFFF, 16'h7FFF, 8'd0,   16'h0000, 16'h8000};
        tbl[2] = '{16'h1234, 16'hABCD, 8'd1,   16'h1235, 16'hABCE};
        tbl[3] = '{16'h00FF, 16'hFF00, 8'd255, 16'h0100, 16'hFF01};
        tbl[4] = '{16'h8000, 16'h0001, 8'd8,   16'h8001, 16'h0002};
        tbl[5] = '{16'h0000, 16'hFFFF, 8'd32,  16'h0001, 16'h0000};
        tbl[6] = '{16'h7FFF, 16'h8000, 8'd3,   16'h8000, 16'h8001};
        tbl[7] = '{16'hDEAD, 16'hBEEF, 8'd100, 16'hDEAE, 16'hBEF0};
        tbl[8] = '{16'h0F0F, 16'hF0F0, 8'd12,  16'h0F10, 16'hF0F1};
        tbl[9] = '{16'h5555, 16'hAAAA, 8'd200, 16'h5556, 16'hAAAB};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_sq_start", sq_start, 0);
        chk("rst_sq_x", sq_x, 0);
        chk("rst_sq_N", sq_N, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_real", m_real, 0);
        chk("rst_m_timeout", m_timeout, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single job
        m_ready = 1'b1;
        push(tbl[0], p);
        wait_res(1, 100, "single");
        repeat (5) @(negedge clk);
        chk("single_start_count", start_q.size(), 1);
        if (start_q.size() > 0) chk("single_start_delay", start_q[0].cyc - p, 2);
        chk_job("single", 0, tbl[0]);
        clear_q();

        // Burst with backpressure
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) push(tbl[k], acc[k]);
        for (int k = 1; k < 5; k++) chk($sformatf("burst_push%0d_cycle", k), acc[k] - acc[0], k);
        chk("burst_full_s_ready", s_ready, 0);
        chk("burst_full_count", fifo_count, 4);
        chk("burst_busy", busy, 1);
        s_valid = 1'b1; s_x = tbl[5].x; s_y = tbl[5].y; s_N = tbl[5].n;
        repeat (40) @(negedge clk);
        chk("burst_held_s_ready", s_ready, 0);
        chk("burst_hold_m_valid", m_valid, 1);
        chk("burst_hold_m_real", m_real, tbl[0].er);
        m_ready = 1'b1;
        guard = 0;
        while (!s_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("burst_6th_accept", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
        wait_res(6, 400, "burst");
        for (int k = 0; k < 6; k++) chk_job($sformatf("burst%0d", k), k, tbl[k]);
        repeat (5) @(negedge clk);
        clear_q();

        // Stale valid overlapping the next start
        hold_len = 5;
        push(tbl[6], p);
        push(tbl[7], p);
        wait_res(2, 200, "stale");
        if (res_q.size() > 1 && start_q.size() > 1)
            chk("stale_start_in_window", {31'd0, (start_q[1].cyc <= res_q[0].cyc + 3)}, 1);
        chk_job("stale0", 0, tbl[6]);
        chk_job("stale1", 1, tbl[7]);
        repeat (10) @(negedge clk);
        hold_len = 1;
        clear_q();

        // Timeout, then a normal job
        resp_en = 1'b0;
        push(tbl[8], p);
        push(tbl[9], p);
        repeat (20) @(negedge clk);
        resp_en = 1'b1;
        wait_res(2, 700, "tmo");
        if (res_q.size() > 1 && start_q.size() > 1) begin
            chk("tmo_latency", res_q[0].cyc - start_q[0].cyc, 256);
            chk("tmo_real", res_q[0].r, 0);
            chk("tmo_img", res_q[0].i, 0);
            chk("tmo_flag", res_q[0].t, 1);
        end
        to_v = tbl[9];
        chk_job("after_tmo", 1, to_v);
        repeat (5) @(negedge clk);
        clear_q();

        // Asynchronous reset while a job is in flight with three queued
        for (int k = 0; k < 4; k++) push(tbl[k], acc[k]);
        repeat (5) @(negedge clk);
        chk("mid_pre_count", fifo_count, 3);
        chk("mid_pre_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_s_ready", s_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sq_x", sq_x, 0);
        chk("mid_rst_sq_N", sq_N, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_sq_start", sq_start, 0);
        @(negedge clk);
        rst = 1'b1;
        clear_q();
        repeat (40) @(negedge clk);
        chk("post_rst_no_start", start_q.size(), 0);
        chk("post_rst_no_result", res_q.size(), 0);

        // Pointer wrap-around with spaced single pushes
        max_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            push(tbl[k % 10], p);
            repeat (29) @(negedge clk);
        end
        wait_res(20, 100, "wrap");
        for (int k = 0; k < 20; k++) chk_job($sformatf("wrap%0d", k), k, tbl[k % 10]);
        chk("wrap_max_count", max_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
